// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-stage capture inputs, control, and register-file/forwarding outputs.
interface mem_wb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) ();
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_regWrite;
    logic              mem_memToReg;
    logic [ADDR_W-1:0] mem_writeReg;
    logic [DATA_W-1:0] mem_aluResult;
    logic [DATA_W-1:0] mem_readData;
    logic [ADDR_W-1:0] ex_rs;
    logic [ADDR_W-1:0] ex_rt;

    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              wb_valid;
    logic              fwd_rs_hit;
    logic              fwd_rt_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [31:0]       retired;

    modport master (
        output stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_writeReg,
               mem_aluResult, mem_readData, ex_rs, ex_rt,
        input  regWrite, writeReg, writeData, wb_valid, fwd_rs_hit, fwd_rt_hit,
               fwd_data, retired
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_writeReg,
               mem_aluResult, mem_readData, ex_rs, ex_rt,
        output regWrite, writeReg, writeData, wb_valid, fwd_rs_hit, fwd_rt_hit,
               fwd_data, retired
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: captures MEM results, drives the register-file write port,
// WB->EX forwarding hits and a retired-instruction counter.
module mem_wb_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic   i_clk,
    input  logic   i_rst,
    mem_wb_if.slave bus
);
    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_rd;
    logic              r_written;
    logic [31:0]       r_retired;

    logic              w_wb_wr;
    logic [DATA_W-1:0] w_write_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_write_reg  <= '0;
            r_alu        <= '0;
            r_rd         <= '0;
            r_written    <= 1'b0;
            r_retired    <= '0;
        end else if (bus.flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_written   <= 1'b0;
        end else if (bus.stall) begin
            // Held entry already wrote on its first cycle; block repeats.
            r_written <= 1'b1;
        end else begin
            r_valid      <= bus.mem_valid;
            r_reg_write  <= bus.mem_regWrite;
            r_mem_to_reg <= bus.mem_memToReg;
            r_write_reg  <= bus.mem_writeReg;
            r_alu        <= bus.mem_aluResult;
            r_rd         <= bus.mem_readData;
            r_written    <= 1'b0;
            if (bus.mem_valid) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign w_wb_wr      = r_valid & r_reg_write & (r_write_reg != '0);
    assign w_write_data = r_mem_to_reg ? r_rd : r_alu;

    assign bus.regWrite   = w_wb_wr & ~r_written;
    assign bus.writeReg   = r_write_reg;
    assign bus.writeData  = w_write_data;
    assign bus.wb_valid   = r_valid;
    assign bus.fwd_rs_hit = w_wb_wr & (r_write_reg == bus.ex_rs);
    assign bus.fwd_rt_hit = w_wb_wr & (r_write_reg == bus.ex_rt);
    assign bus.fwd_data   = w_write_data;
    assign bus.retired    = r_retired;
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vector table, then random traffic vs a reference model.
module tb_mem_wb_writeback;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_wb_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic          rst_n;
        logic          stall;
        logic          flush;
        logic          valid;
        logic          rw;
        logic          m2r;
        logic [AW-1:0] dest;
        logic [DW-1:0] alu;
        logic [DW-1:0] rd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          e_rw;
        logic [AW-1:0] e_wr;
        logic [DW-1:0] e_wd;
        logic          e_valid;
        logic          e_rs_hit;
        logic          e_rt_hit;
        logic [31:0]   e_ret;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the current WB entry, whether it was loaded on the last edge,
    // and an integer retire count.
    logic          m_valid, m_rw, m_m2r, m_fresh;
    logic [AW-1:0] m_dest;
    logic [DW-1:0] m_alu, m_rd;
    longint        m_ret;

    task automatic add(input logic rst_n, input logic stall, input logic flush,
                       input logic valid, input logic rw, input logic m2r,
                       input logic [AW-1:0] dest, input logic [DW-1:0] alu,
                       input logic [DW-1:0] rd, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic e_rw, input logic [AW-1:0] e_wr,
                       input logic [DW-1:0] e_wd, input logic e_valid, input logic e_rs_hit,
                       input logic e_rt_hit, input logic [31:0] e_ret);
        vec_t v;
        v = '{rst_n, stall, flush, valid, rw, m2r, dest, alu, rd, rs, rt,
              e_rw, e_wr, e_wd, e_valid, e_rs_hit, e_rt_hit, e_ret};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst_n, input logic stall, input logic flush,
                         input logic valid, input logic rw, input logic m2r,
                         input logic [AW-1:0] dest, input logic [DW-1:0] alu,
                         input logic [DW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt);
        rst               = rst_n;
        bus.stall         = stall;
        bus.flush         = flush;
        bus.mem_valid     = valid;
        bus.mem_regWrite  = rw;
        bus.mem_memToReg  = m2r;
        bus.mem_writeReg  = dest;
        bus.mem_aluResult = alu;
        bus.mem_readData  = rd;
        bus.ex_rs         = rs;
        bus.ex_rt         = rt;
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_fresh = 0;
            m_dest = '0; m_alu = '0; m_rd = '0; m_ret = 0;
        end else if (bus.flush) begin
            m_valid = 0; m_rw = 0; m_fresh = 0;
        end else if (bus.stall) begin
            m_fresh = 0;
        end else begin
            m_valid = bus.mem_valid;   m_rw = bus.mem_regWrite;
            m_m2r   = bus.mem_memToReg; m_dest = bus.mem_writeReg;
            m_alu   = bus.mem_aluResult; m_rd = bus.mem_readData;
            m_fresh = 1;
            if (bus.mem_valid) m_ret = (m_ret + 1) % 64'h1_0000_0000;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rw, input logic [AW-1:0] e_wr,
                           input logic [DW-1:0] e_wd, input logic e_valid,
                           input logic e_rs_hit, input logic e_rt_hit, input logic [31:0] e_ret);
        chk({tag, ".regWrite"},   DW'(bus.regWrite),   DW'(e_rw));
        chk({tag, ".writeReg"},   DW'(bus.writeReg),   DW'(e_wr));
        chk({tag, ".writeData"},  bus.writeData,       e_wd);
        chk({tag, ".fwd_data"},   bus.fwd_data,        e_wd);
        chk({tag, ".wb_valid"},   DW'(bus.wb_valid),   DW'(e_valid));
        chk({tag, ".fwd_rs_hit"}, DW'(bus.fwd_rs_hit), DW'(e_rs_hit));
        chk({tag, ".fwd_rt_hit"}, DW'(bus.fwd_rt_hit), DW'(e_rt_hit));
        chk({tag, ".retired"},    bus.retired,         e_ret);
    endtask

    initial begin
        logic          e_wr_en, e_hit_base;
        logic [DW-1:0] e_wd;
        logic          r_rst, r_st, r_fl, r_v, r_w, r_m;
        drive(0, 0, 0, 1, 1, 0, 5'd1, 32'h1, 32'h2, 5'd0, 5'd0);

        //   rst st fl v  w  m2r dest alu           rd            rs  rt   eRW eWR eWD           eV rsH rtH ret
        add(0, 0, 0, 1, 1, 0, 5'd5, 32'h0000_0012, 32'h0,         5'd0, 5'd0, 0, 5'd0, 32'h0,         0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 5'd5, 32'h0000_0012, 32'h0,         5'd0, 5'd0, 0, 5'd0, 32'h0,         0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 5'd5, 32'h0000_0012, 32'h0,         5'd0, 5'd0, 1, 5'd5, 32'h0000_0012, 1, 0, 0, 1);
        add(1, 0, 0, 1, 1, 1, 5'd3, 32'h0,         32'hDEAD_BEEF, 5'd0, 5'd0, 1, 5'd3, 32'hDEAD_BEEF, 1, 0, 0, 2);
        add(1, 0, 0, 1, 1, 1, 5'd0, 32'h0,         32'hDEAD_BEEF, 5'd0, 5'd0, 0, 5'd0, 32'hDEAD_BEEF, 1, 0, 0, 3);
        add(1, 0, 0, 1, 1, 0, 5'd7, 32'h0000_0077, 32'h0,         5'd7, 5'd0, 1, 5'd7, 32'h0000_0077, 1, 1, 0, 4);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 1, 1, 0, 5'd1, 32'h0000_AAAA, 32'h0,     5'd7, 5'd0, 0, 5'd7, 32'h0000_0077, 1, 1, 0, 4);
        add(1, 1, 1, 1, 1, 0, 5'd7, 32'h0000_0077, 32'h0,         5'd7, 5'd7, 0, 5'd7, 32'h0000_0077, 0, 0, 0, 4);
        add(1, 0, 0, 1, 1, 0, 5'd9, 32'h0000_0099, 32'h0,         5'd9, 5'd9, 1, 5'd9, 32'h0000_0099, 1, 1, 1, 5);
        add(1, 0, 0, 1, 0, 0, 5'd9, 32'h0000_0099, 32'h0,         5'd9, 5'd9, 0, 5'd9, 32'h0000_0099, 1, 0, 0, 6);
        add(1, 0, 0, 0, 1, 0, 5'd9, 32'h0000_0055, 32'h0,         5'd9, 5'd9, 0, 5'd9, 32'h0000_0055, 0, 0, 0, 6);
        add(1, 0, 0, 1, 1, 0, 5'd4, 32'h0000_0044, 32'h0,         5'd4, 5'd0, 1, 5'd4, 32'h0000_0044, 1, 1, 0, 7);
        add(0, 1, 0, 1, 1, 0, 5'd4, 32'h0000_0044, 32'h0,         5'd4, 5'd0, 0, 5'd0, 32'h0,         0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 5'd0, 32'h0,         32'h0,         5'd0, 5'd0, 0, 5'd0, 32'h0,         0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rw,
                  vecs[i].m2r, vecs[i].dest, vecs[i].alu, vecs[i].rd, vecs[i].rs, vecs[i].rt);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wr, vecs[i].e_wd,
                    vecs[i].e_valid, vecs[i].e_rs_hit, vecs[i].e_rt_hit, vecs[i].e_ret);
        end

        // Random traffic: small register range so forwarding hits and $0 occur often.
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 39) != 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_v   = ($urandom_range(0, 4) != 0);
            r_w   = ($urandom_range(0, 3) != 0);
            r_m   = $urandom_range(0, 1) == 1;
            drive(r_rst, r_st, r_fl, r_v, r_w, r_m, AW'($urandom_range(0, 3)), $urandom,
                  $urandom, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
            step();
            e_wd       = m_m2r ? m_rd : m_alu;
            e_hit_base = m_valid && m_rw && (m_dest != 0);
            e_wr_en    = e_hit_base && m_fresh;
            chk_all($sformatf("rnd%0d", n), e_wr_en, m_dest, e_wd, m_valid,
                    e_hit_base && (m_dest == bus.ex_rs), e_hit_base && (m_dest == bus.ex_rt),
                    32'(m_ret));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
